// File: rtl/hamming_secded_stream_decoder_if.sv
// Stream bundle for the SECDED decoder: codeword in, corrected word out.
// Parity count and codeword width are derived from DATA_W.
interface hamming_secded_stream_decoder_if #(
    parameter int DATA_W = 4
);
    function automatic int calc_p(input int dw);
        int p;
        p = 0;
        for (int k = 1; k < 8; k++)
            if (p == 0 && (1 << k) >= dw + k + 1) p = k;
        return p;
    endfunction

    localparam int P      = calc_p(DATA_W);
    localparam int CODE_W = DATA_W + P + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic [P-1:0]      out_syndrome;

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_status, out_syndrome
    );

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_status, out_syndrome
    );
endinterface

// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready back-pressure
// and saturating corrected/uncorrectable word counters.
module hamming_secded_stream_decoder #(
    parameter int DATA_W  = 4,
    parameter int COUNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    hamming_secded_stream_decoder_if.slave  bus,
    input  logic                            clr_counts,
    output logic [COUNT_W-1:0]              corr_count,
    output logic [COUNT_W-1:0]              uncorr_count
);
    function automatic int calc_p(input int dw);
        int p;
        p = 0;
        for (int k = 1; k < 8; k++)
            if (p == 0 && (1 << k) >= dw + k + 1) p = k;
        return p;
    endfunction

    // Hamming position of data bit j: the j-th non-power-of-two position.
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 3; i < 128; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == j && pos == 0) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    localparam int P      = calc_p(DATA_W);
    localparam int CODE_W = DATA_W + P + 1;

    logic              adv;
    logic [P-1:0]      syn_c;
    logic              pe_c;
    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [P-1:0]      s1_syn;
    logic              s1_pe;
    logic [31:0]       syn_w;
    logic [CODE_W-1:0] fixed;
    logic [1:0]        status_c;
    logic [DATA_W-1:0] data_c;
    logic              out_valid_r;
    logic [DATA_W-1:0] data_r;
    logic [1:0]        status_r;
    logic [P-1:0]      syn_r;
    logic              hs;

    // Handshake: a word moves on an edge where valid & ready are both high.
    // Both stages advance together whenever the output slot is empty or
    // being drained, so in_ready never depends on in_valid or in_code.
    assign adv          = bus.out_ready | ~out_valid_r;
    assign bus.in_ready = adv;

    always_comb begin
        syn_c = '0;
        for (int i = 1; i < CODE_W; i++)
            for (int k = 0; k < P; k++)
                if (((i >> k) & 1) == 1) syn_c[k] = syn_c[k] ^ bus.in_code[i-1];
        pe_c = ^bus.in_code;
    end

    always_comb begin
        syn_w    = 32'(s1_syn);
        fixed    = s1_code;
        status_c = 2'b00;
        if (s1_syn == '0) begin
            status_c = s1_pe ? 2'b01 : 2'b00;
        end else if (!s1_pe) begin
            status_c = 2'b10;
        end else if (syn_w <= 32'(CODE_W - 1)) begin
            status_c = 2'b01;
            for (int i = 1; i < CODE_W; i++)
                if (syn_w == 32'(i)) fixed[i-1] = ~s1_code[i-1];
        end else begin
            // Syndrome beyond the codeword: only reachable on shortened codes.
            status_c = 2'b10;
        end
    end

    for (genvar gj = 0; gj < DATA_W; gj++) begin : g_data
        localparam int POS = data_pos(gj);
        assign data_c[gj] = fixed[POS-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_code     <= '0;
            s1_syn      <= '0;
            s1_pe       <= 1'b0;
            out_valid_r <= 1'b0;
            data_r      <= '0;
            status_r    <= 2'b00;
            syn_r       <= '0;
        end else if (adv) begin
            s1_valid    <= bus.in_valid;
            s1_code     <= bus.in_code;
            s1_syn      <= syn_c;
            s1_pe       <= pe_c;
            out_valid_r <= s1_valid;
            data_r      <= data_c;
            status_r    <= status_c;
            syn_r       <= s1_syn;
        end
    end

    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = data_r;
    assign bus.out_status   = status_r;
    assign bus.out_syndrome = syn_r;

    assign hs = out_valid_r & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (clr_counts) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (hs) begin
            if (status_r == 2'b01 && corr_count != '1)
                corr_count <= corr_count + COUNT_W'(1);
            if (status_r == 2'b10 && uncorr_count != '1)
                uncorr_count <= uncorr_count + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Directed bench for the SECDED stream decoder at DATA_W 4/11/26/57, including
// back-pressure, counter saturation/clear and mid-stream reset.
`timescale 1ns/1ps
module tb_hamming_secded_stream_decoder;
    logic clk;
    logic rst;
    logic a_clr, b_clr, w_clr;
    logic [15:0] a_corr, a_uncorr;
    logic [1:0]  b_corr, b_uncorr;
    logic [15:0] c_corr, c_uncorr, d_corr, d_uncorr, e_corr, e_uncorr;

    int n_vec = 0;
    int n_bad = 0;
    int m_corr = 0;
    int m_uncorr = 0;

    hamming_secded_stream_decoder_if #(.DATA_W(4))  a_if ();
    hamming_secded_stream_decoder_if #(.DATA_W(4))  b_if ();
    hamming_secded_stream_decoder_if #(.DATA_W(11)) c_if ();
    hamming_secded_stream_decoder_if #(.DATA_W(26)) d_if ();
    hamming_secded_stream_decoder_if #(.DATA_W(57)) e_if ();

    hamming_secded_stream_decoder #(.DATA_W(4), .COUNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if), .clr_counts(a_clr),
        .corr_count(a_corr), .uncorr_count(a_uncorr));
    hamming_secded_stream_decoder #(.DATA_W(4), .COUNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if), .clr_counts(b_clr),
        .corr_count(b_corr), .uncorr_count(b_uncorr));
    hamming_secded_stream_decoder #(.DATA_W(11), .COUNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .bus(c_if), .clr_counts(w_clr),
        .corr_count(c_corr), .uncorr_count(c_uncorr));
    hamming_secded_stream_decoder #(.DATA_W(26), .COUNT_W(16)) dut_d (
        .clk(clk), .rst(rst), .bus(d_if), .clr_counts(w_clr),
        .corr_count(d_corr), .uncorr_count(d_uncorr));
    hamming_secded_stream_decoder #(.DATA_W(57), .COUNT_W(16)) dut_e (
        .clk(clk), .rst(rst), .bus(e_if), .clr_counts(w_clr),
        .corr_count(e_corr), .uncorr_count(e_uncorr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int tb_p(input int dw);
        int p;
        p = 0;
        for (int k = 1; k < 8; k++)
            if (p == 0 && (1 << k) >= dw + k + 1) p = k;
        return p;
    endfunction

    function automatic logic [63:0] encode(input int dw, input logic [63:0] d);
        logic [63:0] c;
        logic par;
        int p, cw, j;
        p  = tb_p(dw);
        cw = dw + p + 1;
        c  = '0;
        j  = 0;
        for (int i = 1; i < cw; i++)
            if ((i & (i - 1)) != 0) begin c[i-1] = d[j]; j++; end
        for (int k = 0; k < p; k++) begin
            par = 1'b0;
            for (int i = 1; i < cw; i++)
                if (((i >> k) & 1) == 1 && (i & (i - 1)) != 0) par ^= c[i-1];
            c[(1 << k) - 1] = par;
        end
        par = 1'b0;
        for (int i = 0; i < cw - 1; i++) par ^= c[i];
        c[cw-1] = par;
        return c;
    endfunction

    function automatic logic [63:0] extract(input int dw, input logic [63:0] c);
        logic [63:0] d;
        int p, j;
        p = tb_p(dw);
        d = '0;
        j = 0;
        for (int i = 1; i < dw + p + 1; i++)
            if ((i & (i - 1)) != 0) begin d[j] = c[i-1]; j++; end
        return d;
    endfunction

    // One isolated word through instance A; called and returns at posedge+1 with an empty pipe.
    task automatic run_a(input logic [7:0] code, input logic [3:0] ed, input logic [1:0] es,
                         input logic [2:0] esyn);
        a_if.in_code  = code;
        a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        check("a_latency_gap", a_if.out_valid, 0);
        @(posedge clk); #1;
        check("a_valid", a_if.out_valid, 1);
        check("a_data", a_if.out_data, ed);
        check("a_status", a_if.out_status, es);
        check("a_syndrome", a_if.out_syndrome, esyn);
        @(posedge clk); #1;
        if (es == 2'b01) m_corr++;
        if (es == 2'b10) m_uncorr++;
        check("a_corr_count", a_corr, m_corr);
        check("a_uncorr_count", a_uncorr, m_uncorr);
    endtask

    task automatic run_wide(input int kind);
        int dws[3];
        logic [63:0] wcode[3], wdata[3];
        logic [1:0]  wst[3];
        logic [7:0]  wsyn[3];
        dws = '{11, 26, 57};
        for (int w = 0; w < 3; w++) begin
            int cw, pa, pb;
            logic [63:0] d;
            cw = dws[w] + tb_p(dws[w]) + 1;
            d  = {$urandom(), $urandom()} & ((64'd1 << dws[w]) - 64'd1);
            wcode[w] = encode(dws[w], d);
            wdata[w] = d;
            wst[w]   = 2'b00;
            wsyn[w]  = 8'd0;
            if (kind == 1) begin
                pa = $urandom_range(1, cw - 1);
                wcode[w][pa-1] = ~wcode[w][pa-1];
                wst[w]  = 2'b01;
                wsyn[w] = 8'(pa);
            end else if (kind == 2) begin
                pa = $urandom_range(1, cw - 1);
                pb = $urandom_range(1, cw - 2);
                if (pb >= pa) pb++;
                wcode[w][pa-1] = ~wcode[w][pa-1];
                wcode[w][pb-1] = ~wcode[w][pb-1];
                wst[w]   = 2'b10;
                wsyn[w]  = 8'(pa ^ pb);
                wdata[w] = extract(dws[w], wcode[w]);
            end else if (kind == 3) begin
                wcode[w][cw-1] = ~wcode[w][cw-1];
                wst[w] = 2'b01;
            end
        end
        c_if.in_code = wcode[0][15:0];
        d_if.in_code = wcode[1][31:0];
        e_if.in_code = wcode[2];
        c_if.in_valid = 1'b1; d_if.in_valid = 1'b1; e_if.in_valid = 1'b1;
        @(posedge clk); #1;
        c_if.in_valid = 1'b0; d_if.in_valid = 1'b0; e_if.in_valid = 1'b0;
        @(posedge clk); #1;
        check("w11_valid", c_if.out_valid, 1);
        check("w11_data", c_if.out_data, wdata[0]);
        check("w11_status", c_if.out_status, wst[0]);
        check("w11_syndrome", c_if.out_syndrome, wsyn[0]);
        check("w26_valid", d_if.out_valid, 1);
        check("w26_data", d_if.out_data, wdata[1]);
        check("w26_status", d_if.out_status, wst[1]);
        check("w26_syndrome", d_if.out_syndrome, wsyn[1]);
        check("w57_valid", e_if.out_valid, 1);
        check("w57_data", e_if.out_data, wdata[2]);
        check("w57_status", e_if.out_status, wst[2]);
        check("w57_syndrome", e_if.out_syndrome, wsyn[2]);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [8:0] exp_q[$];
        logic [8:0] exps[10];
        logic [7:0] codes[10];
        logic [8:0] held, e;
        logic [7:0] c8;
        logic [63:0] enc;
        bit was_stalled;
        int sent, got, f;

        rst = 1'b1;
        a_clr = 1'b0; b_clr = 1'b0; w_clr = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_code = '0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_code = '0; b_if.out_ready = 1'b1;
        c_if.in_valid = 1'b0; c_if.in_code = '0; c_if.out_ready = 1'b1;
        d_if.in_valid = 1'b0; d_if.in_code = '0; d_if.out_ready = 1'b1;
        e_if.in_valid = 1'b0; e_if.in_code = '0; e_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", a_if.in_ready, 1);
        check("rst_out_valid", a_if.out_valid, 0);
        check("rst_data", a_if.out_data, 0);
        check("rst_status", a_if.out_status, 0);
        check("rst_syndrome", a_if.out_syndrome, 0);
        check("rst_corr", a_corr, 0);
        check("rst_uncorr", a_uncorr, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", a_if.in_ready, 1);
        check("post_rst_valid", a_if.out_valid, 0);

        // Clean words, every single-bit flip, and a double error
        run_a(8'h55, 4'b1011, 2'b00, 3'd0);
        run_a(8'hFF, 4'b1111, 2'b00, 3'd0);
        run_a(8'h00, 4'b0000, 2'b00, 3'd0);
        for (int b = 0; b < 8; b++)
            run_a(8'h55 ^ (8'h01 << b), 4'b1011, 2'b01, (b < 7) ? 3'(b + 1) : 3'd0);
        run_a(8'h47, 4'b1001, 2'b10, 3'd7);

        // Stream with random back-pressure
        for (int i = 0; i < 10; i++) begin
            logic [3:0] dd;
            dd  = 4'($urandom_range(0, 15));
            enc = encode(4, 64'(dd));
            c8  = enc[7:0];
            f   = $urandom_range(0, 8);
            if (f < 8) c8[f] = ~c8[f];
            codes[i] = c8;
            exps[i]  = {dd, (f < 8) ? 2'b01 : 2'b00, (f < 7) ? 3'(f + 1) : 3'd0};
        end
        sent = 0; got = 0; was_stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            a_if.out_ready = ($urandom_range(0, 1) == 1);
            a_if.in_valid  = (sent < 10);
            a_if.in_code   = codes[(sent < 10) ? sent : 0];
            #1;
            if (was_stalled) begin
                check("hold_valid", a_if.out_valid, 1);
                check("hold_outputs", {a_if.out_data, a_if.out_status, a_if.out_syndrome}, held);
            end
            if (a_if.out_valid && !a_if.out_ready) check("stall_in_ready", a_if.in_ready, 0);
            if (a_if.out_ready) check("go_in_ready", a_if.in_ready, 1);
            was_stalled = a_if.out_valid && !a_if.out_ready;
            held = {a_if.out_data, a_if.out_status, a_if.out_syndrome};
            if (a_if.out_valid && a_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_word", held, e);
                    if (e[4:3] == 2'b01) m_corr++;
                    if (e[4:3] == 2'b10) m_uncorr++;
                end
                got++;
            end
            if (a_if.in_valid && a_if.in_ready) begin
                exp_q.push_back(exps[sent]);
                sent++;
            end
            @(posedge clk); #1;
        end
        a_if.in_valid = 1'b0;
        a_if.out_ready = 1'b1;
        check("stream_count", got, 10);
        check("stream_leftover", exp_q.size(), 0);
        check("stream_corr", a_corr, m_corr);
        check("stream_uncorr", a_uncorr, m_uncorr);

        // Saturating 2-bit counter, clear coinciding with a corrected handshake
        b_if.in_code = 8'h45;
        b_if.in_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (n == 5) b_if.in_valid = 1'b0;
            if (n == 3) check("sat_count_2", b_corr, 2);
            if (n == 5) check("sat_count_held", b_corr, 3);
            if (n == 6) begin
                check("sat_count_3", b_corr, 3);
                check("sat_sixth_valid", b_if.out_valid, 1);
                check("sat_sixth_status", b_if.out_status, 2'b01);
                b_clr = 1'b1;
            end
            if (n == 7) begin
                check("clr_count_0", b_corr, 0);
                check("clr_uncorr_0", b_uncorr, 0);
                b_clr = 1'b0;
            end
        end

        // Reset with two words in flight
        a_if.in_code = 8'h55; a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        a_if.in_code = 8'hFF;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        check("flight_valid", a_if.out_valid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", a_if.out_valid, 0);
        check("async_rst_in_ready", a_if.in_ready, 1);
        check("async_rst_corr", a_corr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_corr = 0; m_uncorr = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check("no_stale_output", a_if.out_valid, 0);
        end
        run_a(8'h45, 4'b1011, 2'b01, 3'd5);

        // Wider codes: clean, single, double, overall-parity flip
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                run_wide(k);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
